// File: rtl/mod_counter_disp_if.sv
// Control and readout bundle for mod_counter_disp.
// The slave side is the counter; the master side is the lab top level.
interface mod_counter_disp_if #(
   parameter int unsigned WIDTH = 3
);
   logic             iEn;
   logic             iUp;
   logic             iLoad;
   logic [WIDTH-1:0] iLoadVal;
   logic [WIDTH-1:0] oQ;
   logic             oTick;
   logic             oTC;
   logic [6:0]       oDisplay;

   modport master (
      output iEn, iUp, iLoad, iLoadVal,
      input  oQ, oTick, oTC, oDisplay
   );

   modport slave (
      input  iEn, iUp, iLoad, iLoadVal,
      output oQ, oTick, oTC, oDisplay
   );
endinterface

// File: rtl/mod_counter_disp.sv
// Modulo-N up/down counter with clock-enable prescaler, load, wrap/saturate ends,
// terminal-count pulse and an active-low 7-segment readout of the low nibble.
module mod_counter_disp #(
   parameter int unsigned WIDTH    = 3,
   parameter int unsigned MODULUS  = 8,
   parameter int unsigned DIV      = 1,
   parameter bit          SATURATE = 1'b0
) (
   input logic               CLK,
   input logic               Rst,
   mod_counter_disp_if.slave bus
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

   logic             step;
   logic [WIDTH-1:0] q_q, q_d;
   logic             tick_q, tick_d;
   logic             tc_q, tc_d;
   logic [6:0]       disp_q, disp_d;

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // With DIV=1 every enabled clock is a step, so no prescaler state exists.
   generate
      if (DIV == 1) begin : g_nodiv
         assign step = bus.iEn;
      end else begin : g_div
         localparam int unsigned   PW     = $clog2(DIV);
         localparam logic [PW-1:0] PreMax = PW'(DIV - 1);

         logic [PW-1:0] pre_q, pre_d;

         assign step = bus.iEn && (pre_q == PreMax);

         always_comb begin
            pre_d = pre_q;
            if (bus.iLoad) begin
               pre_d = '0;
            end else if (bus.iEn) begin
               pre_d = (pre_q == PreMax) ? '0 : pre_q + PW'(1);
            end
         end

         always_ff @(posedge CLK or posedge Rst) begin
            if (Rst) begin
               pre_q <= '0;
            end else begin
               pre_q <= pre_d;
            end
         end
      end
   endgenerate

   always_comb begin
      q_d    = q_q;
      tick_d = 1'b0;
      tc_d   = 1'b0;
      if (bus.iLoad) begin
         q_d = (bus.iLoadVal > MaxVal) ? MaxVal : bus.iLoadVal;
      end else if (step) begin
         tick_d = 1'b1;
         if (bus.iUp) begin
            if (q_q == MaxVal) begin
               tc_d = 1'b1;
               q_d  = SATURATE ? q_q : '0;
            end else begin
               q_d = q_q + WIDTH'(1);
            end
         end else begin
            if (q_q == '0) begin
               tc_d = 1'b1;
               q_d  = SATURATE ? q_q : MaxVal;
            end else begin
               q_d = q_q - WIDTH'(1);
            end
         end
      end
      // Decode from the next count so the segments change on the same edge as oQ.
      disp_d = seg7(4'(q_d));
   end

   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         q_q    <= '0;
         tick_q <= 1'b0;
         tc_q   <= 1'b0;
         disp_q <= 7'h40;
      end else begin
         q_q    <= q_d;
         tick_q <= tick_d;
         tc_q   <= tc_d;
         disp_q <= disp_d;
      end
   end

   assign bus.oQ       = q_q;
   assign bus.oTick    = tick_q;
   assign bus.oTC      = tc_q;
   assign bus.oDisplay = disp_q;

endmodule

// File: tb/tb_mod_counter_disp.sv
// Bench for mod_counter_disp: four parameterisations driven in lockstep, checked by
// a directed vector table, corner-case sequences and a randomized run against a model.
module tb_mod_counter_disp;

   localparam int N = 4;

   logic       CLK = 1'b0;
   logic       Rst;
   logic       en, up, ld;
   logic [4:0] lval;

   always #5 CLK = ~CLK;

   mod_counter_disp_if #(.WIDTH(3)) if0 ();
   mod_counter_disp_if #(.WIDTH(3)) if1 ();
   mod_counter_disp_if #(.WIDTH(3)) if2 ();
   mod_counter_disp_if #(.WIDTH(5)) if3 ();

   assign if0.iEn = en; assign if0.iUp = up; assign if0.iLoad = ld; assign if0.iLoadVal = lval[2:0];
   assign if1.iEn = en; assign if1.iUp = up; assign if1.iLoad = ld; assign if1.iLoadVal = lval[2:0];
   assign if2.iEn = en; assign if2.iUp = up; assign if2.iLoad = ld; assign if2.iLoadVal = lval[2:0];
   assign if3.iEn = en; assign if3.iUp = up; assign if3.iLoad = ld; assign if3.iLoadVal = lval;

   mod_counter_disp #(.WIDTH(3), .MODULUS(8), .DIV(1), .SATURATE(1'b0)) u0 (
      .CLK(CLK), .Rst(Rst), .bus(if0));
   mod_counter_disp #(.WIDTH(3), .MODULUS(8), .DIV(4), .SATURATE(1'b0)) u1 (
      .CLK(CLK), .Rst(Rst), .bus(if1));
   mod_counter_disp #(.WIDTH(3), .MODULUS(6), .DIV(1), .SATURATE(1'b1)) u2 (
      .CLK(CLK), .Rst(Rst), .bus(if2));
   mod_counter_disp #(.WIDTH(5), .MODULUS(20), .DIV(3), .SATURATE(1'b0)) u3 (
      .CLK(CLK), .Rst(Rst), .bus(if3));

   logic [15:0] dq[N];
   logic        dtick[N], dtc[N];
   logic [6:0]  dseg[N];

   assign dq[0] = 16'(if0.oQ); assign dtick[0] = if0.oTick; assign dtc[0] = if0.oTC;
   assign dq[1] = 16'(if1.oQ); assign dtick[1] = if1.oTick; assign dtc[1] = if1.oTC;
   assign dq[2] = 16'(if2.oQ); assign dtick[2] = if2.oTick; assign dtc[2] = if2.oTC;
   assign dq[3] = 16'(if3.oQ); assign dtick[3] = if3.oTick; assign dtc[3] = if3.oTC;
   assign dseg[0] = if0.oDisplay; assign dseg[1] = if1.oDisplay;
   assign dseg[2] = if2.oDisplay; assign dseg[3] = if3.oDisplay;

   int ws[N]   = '{3, 3, 3, 5};
   int mods[N] = '{8, 8, 6, 20};
   int divs[N] = '{1, 4, 1, 3};
   bit sats[N] = '{1'b0, 1'b0, 1'b1, 1'b0};

   logic [6:0] seg_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference state: count, prescaler phase and the one-cycle pulses.
   int mq[N], mpre[N];
   bit mtick[N], mtc[N];

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         mq[k] = 0; mpre[k] = 0; mtick[k] = 1'b0; mtc[k] = 1'b0;
      end
   endtask

   task automatic model_clock();
      for (int k = 0; k < N; k++) begin
         int lv;
         lv       = int'(lval) % (1 << ws[k]);
         mtick[k] = 1'b0;
         mtc[k]   = 1'b0;
         if (ld) begin
            mq[k]   = (lv >= mods[k]) ? mods[k] - 1 : lv;
            mpre[k] = 0;
         end else if (en) begin
            mpre[k] = (mpre[k] + 1) % divs[k];
            if (mpre[k] == 0) begin
               mtick[k] = 1'b1;
               if (up) begin
                  mtc[k] = (mq[k] == mods[k] - 1);
                  if (!(sats[k] && mtc[k])) mq[k] = (mq[k] + 1) % mods[k];
               end else begin
                  mtc[k] = (mq[k] == 0);
                  if (!(sats[k] && mtc[k])) mq[k] = (mq[k] + mods[k] - 1) % mods[k];
               end
            end
         end
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < N; k++) begin
         check($sformatf("model u%0d.q", k), 32'(dq[k]), 32'(mq[k]));
         check($sformatf("model u%0d.tick", k), 32'(dtick[k]), 32'(mtick[k]));
         check($sformatf("model u%0d.tc", k), 32'(dtc[k]), 32'(mtc[k]));
         check($sformatf("model u%0d.seg", k), 32'(dseg[k]), 32'(seg_tab[mq[k] % 16]));
      end
   endtask

   task automatic tick_clk();
      @(posedge CLK);
      if (!Rst) model_clock();
      #1;
      check_model();
   endtask

   typedef struct {
      bit         en, up, ld;
      logic [4:0] lv;
      int         q;
      bit         tk, tc;
      logic [6:0] seg;
   } vec_t;

   vec_t tab[$];

   initial begin
      int ticks;

      tab.push_back('{1'b1, 1'b1, 1'b0, 5'd0, 1, 1'b1, 1'b0, 7'h79});
      tab.push_back('{1'b1, 1'b1, 1'b0, 5'd0, 2, 1'b1, 1'b0, 7'h24});
      tab.push_back('{1'b1, 1'b1, 1'b0, 5'd0, 3, 1'b1, 1'b0, 7'h30});
      tab.push_back('{1'b1, 1'b1, 1'b0, 5'd0, 4, 1'b1, 1'b0, 7'h19});
      tab.push_back('{1'b1, 1'b1, 1'b0, 5'd0, 5, 1'b1, 1'b0, 7'h12});
      tab.push_back('{1'b1, 1'b1, 1'b0, 5'd0, 6, 1'b1, 1'b0, 7'h02});
      tab.push_back('{1'b1, 1'b1, 1'b0, 5'd0, 7, 1'b1, 1'b0, 7'h78});
      tab.push_back('{1'b1, 1'b1, 1'b0, 5'd0, 0, 1'b1, 1'b1, 7'h40});
      tab.push_back('{1'b1, 1'b1, 1'b0, 5'd0, 1, 1'b1, 1'b0, 7'h79});
      tab.push_back('{1'b1, 1'b1, 1'b0, 5'd0, 2, 1'b1, 1'b0, 7'h24});
      tab.push_back('{1'b1, 1'b1, 1'b1, 5'd5, 5, 1'b0, 1'b0, 7'h12});
      tab.push_back('{1'b1, 1'b0, 1'b0, 5'd0, 4, 1'b1, 1'b0, 7'h19});
      tab.push_back('{1'b0, 1'b0, 1'b1, 5'd6, 6, 1'b0, 1'b0, 7'h02});
      tab.push_back('{1'b0, 1'b0, 1'b0, 5'd0, 6, 1'b0, 1'b0, 7'h02});
      tab.push_back('{1'b1, 1'b1, 1'b0, 5'd0, 7, 1'b1, 1'b0, 7'h78});
      tab.push_back('{1'b1, 1'b1, 1'b0, 5'd0, 0, 1'b1, 1'b1, 7'h40});
      tab.push_back('{1'b1, 1'b0, 1'b0, 5'd0, 7, 1'b1, 1'b1, 7'h78});
      tab.push_back('{1'b1, 1'b1, 1'b1, 5'd7, 7, 1'b0, 1'b0, 7'h78});
      tab.push_back('{1'b1, 1'b1, 1'b1, 5'h1A, 2, 1'b0, 1'b0, 7'h24});

      Rst = 1'b1; en = 1'b1; up = 1'b1; ld = 1'b0; lval = '0;
      model_reset();

      for (int i = 0; i < 5; i++) begin
         tick_clk();
         check("reset q", 32'(dq[0]), 32'd0);
         check("reset seg", 32'(dseg[0]), 32'h40);
         check("reset tc", 32'(dtc[0]), 32'd0);
      end
      #2 Rst = 1'b0;

      for (int i = 0; i < tab.size(); i++) begin
         en = tab[i].en; up = tab[i].up; ld = tab[i].ld; lval = tab[i].lv;
         tick_clk();
         check($sformatf("vec%0d q", i), 32'(dq[0]), 32'(tab[i].q));
         check($sformatf("vec%0d tick", i), 32'(dtick[0]), 32'(tab[i].tk));
         check($sformatf("vec%0d tc", i), 32'(dtc[0]), 32'(tab[i].tc));
         check($sformatf("vec%0d seg", i), 32'(dseg[0]), 32'(tab[i].seg));
      end

      // Prescaler on u1 (DIV=4): 8 enabled clocks give two steps.
      ld = 1'b1; lval = 5'd0; en = 1'b1; up = 1'b1;
      tick_clk();
      ld = 1'b0; ticks = 0;
      for (int i = 0; i < 8; i++) begin
         tick_clk();
         ticks += int'(dtick[1]);
      end
      check("presc ticks", 32'(ticks), 32'd2);
      check("presc q", 32'(dq[1]), 32'd2);
      tick_clk();
      tick_clk();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick_clk();
         check("gated q", 32'(dq[1]), 32'd2);
         check("gated tick", 32'(dtick[1]), 32'd0);
      end
      en = 1'b1;
      tick_clk();
      check("resume q hold", 32'(dq[1]), 32'd2);
      tick_clk();
      check("resume q step", 32'(dq[1]), 32'd3);
      check("resume tick", 32'(dtick[1]), 32'd1);

      // Saturating down count on u2 (MOD=6).
      ld = 1'b1; lval = 5'd1; up = 1'b0;
      tick_clk();
      ld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick_clk();
         check("sat q", 32'(dq[2]), 32'd0);
         check("sat tc", 32'(dtc[2]), (i == 0) ? 32'd0 : 32'd1);
      end
      up = 1'b1;
      tick_clk();
      check("sat up q", 32'(dq[2]), 32'd1);
      check("sat up tc", 32'(dtc[2]), 32'd0);

      // Load clamping and load with the enable low.
      ld = 1'b1; lval = 5'd7;
      tick_clk();
      check("clamp u2", 32'(dq[2]), 32'd5);
      check("noclamp u0", 32'(dq[0]), 32'd7);
      en = 1'b0; lval = 5'd4;
      tick_clk();
      check("load en0 u2", 32'(dq[2]), 32'd4);
      check("load en0 u1", 32'(dq[1]), 32'd4);

      // Load landing on a prescaler step restarts the phase.
      en = 1'b1; lval = 5'd0;
      tick_clk();
      ld = 1'b0;
      for (int i = 0; i < 3; i++) tick_clk();
      ld = 1'b1; lval = 5'd3;
      tick_clk();
      check("load step q", 32'(dq[1]), 32'd3);
      check("load step tick", 32'(dtick[1]), 32'd0);
      ld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick_clk();
         check("post load hold", 32'(dq[1]), 32'd3);
      end
      tick_clk();
      check("post load step", 32'(dq[1]), 32'd4);

      // Asynchronous reset between edges.
      ld = 1'b1; lval = 5'd4;
      tick_clk();
      ld = 1'b0;
      tick_clk();
      check("pre-reset q", 32'(dq[0]), 32'd5);
      #3 Rst = 1'b1;
      model_reset();
      #1;
      check("async q u0", 32'(dq[0]), 32'd0);
      check("async seg u0", 32'(dseg[0]), 32'h40);
      check("async q u1", 32'(dq[1]), 32'd0);
      tick_clk();
      #2 Rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick_clk();
         check("restart u1 hold", 32'(dq[1]), 32'd0);
      end
      tick_clk();
      check("restart u1 step", 32'(dq[1]), 32'd1);
      check("restart u0", 32'(dq[0]), 32'd4);

      for (int i = 0; i < 400; i++) begin
         en   = ($urandom_range(0, 3) != 0);
         up   = 1'(($urandom_range(0, 1)));
         ld   = ($urandom_range(0, 15) == 0);
         lval = 5'($urandom);
         tick_clk();
         if ($urandom_range(0, 99) == 0) begin
            #2 Rst = 1'b1;
            model_reset();
            #1 Rst = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
